// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit stability counter for a bank of slide switches.
// Produces a debounced vector and registered one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int  WIDTH         = 8,
  parameter int  STABLE_CYCLES = 500000,
  localparam int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // sync1_q is the metastability-capture stage; it feeds s_q with no logic between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      s_q       <= '0;
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sw;
      s_q       <= sync1_q;
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per bit: a match clears the count; a mismatch counts up and flips the
  // debounced value once it has persisted for STABLE_CYCLES evaluations.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i]   = s_q[i];
          rise_d[i] = s_q[i];
          fall_d[i] = ~s_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_comb begin
    sw_db   = db_q;
    sw_rise = rise_q;
    sw_fall = fall_q;
    changed = changed_q;
  end

endmodule
